// File: rtl/prim_subreg_arb_mh.sv
// Multi-host register slice: one storage register with SW access semantics,
// shared by NumHw hardware writers through a round-robin arbiter with pending buffers.

package prim_subreg_pkg;
    typedef enum logic [2:0] {
        SwAccessRW,
        SwAccessRO,
        SwAccessWO,
        SwAccessW1C,
        SwAccessW1S,
        SwAccessW0C,
        SwAccessRC
    } sw_access_e;
endpackage

module prim_subreg_arb_mh
    import prim_subreg_pkg::*;
#(
    parameter int unsigned   DW          = 32,
    parameter int unsigned   NumHw       = 2,
    parameter sw_access_e    SwAccess    = SwAccessRW,
    parameter logic [DW-1:0] ResVal      = '0,
    parameter bit            HoldPending = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we,
    input  logic [DW-1:0]       wd,
    input  logic                re,
    input  logic [NumHw-1:0]    de,
    input  logic [NumHw*DW-1:0] d,
    output logic [DW-1:0]       q,
    output logic [DW-1:0]       qs,
    output logic                qe,
    output logic [NumHw-1:0]    hw_ack,
    output logic [NumHw-1:0]    hw_drop,
    output logic [NumHw-1:0]    pend
);

    localparam int unsigned PW = (NumHw > 1) ? $clog2(NumHw) : 1;

    logic [DW-1:0]    q_q, q_d;
    logic             qe_q, qe_d;
    logic [NumHw-1:0] ack_q, ack_d;
    logic [NumHw-1:0] drop_q, drop_d;
    logic [NumHw-1:0] pend_q, pend_d;
    logic [DW-1:0]    pend_data_q [NumHw];
    logic [DW-1:0]    pend_data_d [NumHw];
    logic [PW-1:0]    rr_q, rr_d;

    logic [NumHw-1:0] req;
    logic [DW-1:0]    ch_data [NumHw];
    logic             sw_block;
    logic             sw_active;
    logic             gnt_valid;
    logic [PW-1:0]    gnt_idx;
    logic [DW-1:0]    base;
    logic [DW-1:0]    next_val;
    int unsigned      cand;
    int unsigned      rr_nxt;

    // A fresh request always supersedes whatever the channel had pending.
    generate
        for (genvar gi = 0; gi < NumHw; gi++) begin : g_chan
            assign req[gi]     = de[gi] | pend_q[gi];
            assign ch_data[gi] = de[gi] ? d[gi*DW +: DW] : pend_data_q[gi];
        end
    endgenerate

    always_comb begin
        sw_block  = 1'b0;
        sw_active = 1'b0;
        case (SwAccess)
            SwAccessRW, SwAccessWO: begin
                sw_block  = we;
                sw_active = we;
            end
            SwAccessW1S, SwAccessW1C, SwAccessW0C: sw_active = we;
            SwAccessRC:                            sw_active = re;
            default:                               sw_active = 1'b0;
        endcase
    end

    // Round-robin: first requester at or after rr_q, wrapping.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        rr_nxt    = 0;
        rr_d      = rr_q;
        for (int unsigned k = 0; k < NumHw; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NumHw) begin
                cand = cand - NumHw;
            end
            if (!gnt_valid && !sw_block && req[PW'(cand)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'(cand);
            end
        end
        if (gnt_valid) begin
            rr_nxt = 32'(gnt_idx) + 1;
            if (rr_nxt >= NumHw) begin
                rr_nxt = 0;
            end
            rr_d = PW'(rr_nxt);
        end
    end

    assign base = gnt_valid ? ch_data[gnt_idx] : q_q;

    always_comb begin
        next_val = base;
        case (SwAccess)
            SwAccessRW, SwAccessWO: next_val = we ? wd : base;
            SwAccessW1S:            next_val = we ? (base | wd) : base;
            SwAccessW1C:            next_val = we ? (base & ~wd) : base;
            SwAccessW0C:            next_val = we ? (base & wd) : base;
            SwAccessRC:             next_val = re ? '0 : base;
            default:                next_val = base;
        endcase
        qe_d = gnt_valid | sw_active;
        q_d  = qe_d ? next_val : q_q;
    end

    always_comb begin
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        ack_d       = '0;
        drop_d      = '0;
        for (int i = 0; i < NumHw; i++) begin
            if (gnt_valid && (gnt_idx == PW'(i))) begin
                pend_d[i] = 1'b0;
                ack_d[i]  = 1'b1;
            end else if (req[i]) begin
                if (HoldPending) begin
                    pend_d[i]      = 1'b1;
                    pend_data_d[i] = ch_data[i];
                end else begin
                    pend_d[i] = 1'b0;
                    drop_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q    <= ResVal;
            qe_q   <= 1'b0;
            ack_q  <= '0;
            drop_q <= '0;
            pend_q <= '0;
            rr_q   <= '0;
            for (int i = 0; i < NumHw; i++) begin
                pend_data_q[i] <= '0;
            end
        end else begin
            q_q         <= q_d;
            qe_q        <= qe_d;
            ack_q       <= ack_d;
            drop_q      <= drop_d;
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign q       = q_q;
    assign qs      = q_q;
    assign qe      = qe_q;
    assign hw_ack  = ack_q;
    assign hw_drop = drop_q;
    assign pend    = pend_q;

endmodule

// File: tb/tb_prim_subreg_arb_mh.sv
// Table-driven bench for prim_subreg_arb_mh: three configurations (RW hold, RW drop, W1C)
// share stimulus; each vector names the instance whose outputs are scored.

module tb_prim_subreg_arb_mh;
    import prim_subreg_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        we    = 1'b0;
    logic [7:0]  wd    = '0;
    logic        re    = 1'b0;
    logic [2:0]  de    = '0;
    logic [23:0] d     = '0;

    logic [7:0] q_o    [3];
    logic [7:0] qs_o   [3];
    logic       qe_o   [3];
    logic [2:0] ack_o  [3];
    logic [2:0] drop_o [3];
    logic [2:0] pend_o [3];

    always #5 clk_i = ~clk_i;

    prim_subreg_arb_mh #(.DW(8), .NumHw(3), .SwAccess(SwAccessRW), .ResVal(8'h00), .HoldPending(1'b1)) u_rw (
        .clk_i(clk_i), .rst_i(rst_i), .we(we), .wd(wd), .re(re), .de(de), .d(d),
        .q(q_o[0]), .qs(qs_o[0]), .qe(qe_o[0]), .hw_ack(ack_o[0]), .hw_drop(drop_o[0]), .pend(pend_o[0]));

    prim_subreg_arb_mh #(.DW(8), .NumHw(3), .SwAccess(SwAccessRW), .ResVal(8'h00), .HoldPending(1'b0)) u_drop (
        .clk_i(clk_i), .rst_i(rst_i), .we(we), .wd(wd), .re(re), .de(de), .d(d),
        .q(q_o[1]), .qs(qs_o[1]), .qe(qe_o[1]), .hw_ack(ack_o[1]), .hw_drop(drop_o[1]), .pend(pend_o[1]));

    prim_subreg_arb_mh #(.DW(8), .NumHw(3), .SwAccess(SwAccessW1C), .ResVal(8'h00), .HoldPending(1'b1)) u_w1c (
        .clk_i(clk_i), .rst_i(rst_i), .we(we), .wd(wd), .re(re), .de(de), .d(d),
        .q(q_o[2]), .qs(qs_o[2]), .qe(qe_o[2]), .hw_ack(ack_o[2]), .hw_drop(drop_o[2]), .pend(pend_o[2]));

    typedef struct {
        int         sel;
        bit         rst;
        bit         we;
        logic [7:0] wd;
        bit         re;
        logic [2:0] de;
        logic [23:0] d;
        logic [7:0] q;
        bit         qe;
        logic [2:0] ack;
        logic [2:0] drop;
        logic [2:0] pend;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(int sel, bit rst, bit w, logic [7:0] wdat, bit r, logic [2:0] dei,
                                logic [23:0] dat, logic [7:0] eq, bit eqe, logic [2:0] eack,
                                logic [2:0] edrop, logic [2:0] epend);
        vec_t v;
        v.sel = sel; v.rst = rst; v.we = w; v.wd = wdat; v.re = r; v.de = dei; v.d = dat;
        v.q = eq; v.qe = eqe; v.ack = eack; v.drop = edrop; v.pend = epend;
        return v;
    endfunction

    task automatic chk(int idx, string name, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL vec %0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
        end
    endtask

    initial begin
        // RW, hold-pending: uncontested write, round-robin, SW blocking, mid-op reset
        vecs.push_back(mk(0,1,0,8'h00,0,3'b000,24'h000000, 8'h00,0,3'b000,3'b000,3'b000));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b000,24'h000000, 8'h00,0,3'b000,3'b000,3'b000));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b010,24'h00A500, 8'hA5,1,3'b010,3'b000,3'b000));
        vecs.push_back(mk(0,1,0,8'h00,0,3'b000,24'h000000, 8'h00,0,3'b000,3'b000,3'b000));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b111,24'h332211, 8'h11,1,3'b001,3'b000,3'b110));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b000,24'h000000, 8'h22,1,3'b010,3'b000,3'b100));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b000,24'h000000, 8'h33,1,3'b100,3'b000,3'b000));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b000,24'h000000, 8'h33,0,3'b000,3'b000,3'b000));
        vecs.push_back(mk(0,0,1,8'h55,0,3'b100,24'h770000, 8'h55,1,3'b000,3'b000,3'b100));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b000,24'h000000, 8'h77,1,3'b100,3'b000,3'b000));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b111,24'h665544, 8'h44,1,3'b001,3'b000,3'b110));
        vecs.push_back(mk(0,1,0,8'h00,0,3'b000,24'h000000, 8'h00,0,3'b000,3'b000,3'b000));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b111,24'h030201, 8'h01,1,3'b001,3'b000,3'b110));
        // new de on a pending channel commits the new data
        vecs.push_back(mk(0,0,0,8'h00,0,3'b010,24'h00BB00, 8'hBB,1,3'b010,3'b000,3'b100));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b100,24'hCC0000, 8'hCC,1,3'b100,3'b000,3'b000));
        vecs.push_back(mk(0,0,1,8'h10,0,3'b010,24'h00D100, 8'h10,1,3'b000,3'b000,3'b010));
        vecs.push_back(mk(0,0,1,8'h20,0,3'b010,24'h00D200, 8'h20,1,3'b000,3'b000,3'b010));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b000,24'h000000, 8'hD2,1,3'b010,3'b000,3'b000));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b011,24'h00E1E0, 8'hE0,1,3'b001,3'b000,3'b010));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b000,24'h000000, 8'hE1,1,3'b010,3'b000,3'b000));
        // two channels requesting continuously alternate
        vecs.push_back(mk(0,0,0,8'h00,0,3'b101,24'hA200A0, 8'hA2,1,3'b100,3'b000,3'b001));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b101,24'hA200A0, 8'hA0,1,3'b001,3'b000,3'b100));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b101,24'hA200A0, 8'hA2,1,3'b100,3'b000,3'b001));
        vecs.push_back(mk(0,0,0,8'h00,0,3'b000,24'h000000, 8'hA0,1,3'b001,3'b000,3'b000));
        // RW, drop mode
        vecs.push_back(mk(1,1,0,8'h00,0,3'b000,24'h000000, 8'h00,0,3'b000,3'b000,3'b000));
        vecs.push_back(mk(1,0,0,8'h00,0,3'b111,24'h332211, 8'h11,1,3'b001,3'b110,3'b000));
        vecs.push_back(mk(1,0,0,8'h00,0,3'b000,24'h000000, 8'h11,0,3'b000,3'b000,3'b000));
        vecs.push_back(mk(1,0,1,8'h5A,0,3'b001,24'h000099, 8'h5A,1,3'b000,3'b001,3'b000));
        vecs.push_back(mk(1,0,0,8'h00,0,3'b011,24'h008877, 8'h88,1,3'b010,3'b001,3'b000));
        // W1C: SW clear wins bitwise over simultaneous HW data
        vecs.push_back(mk(2,1,0,8'h00,0,3'b000,24'h000000, 8'h00,0,3'b000,3'b000,3'b000));
        vecs.push_back(mk(2,0,0,8'h00,0,3'b001,24'h00000F, 8'h0F,1,3'b001,3'b000,3'b000));
        vecs.push_back(mk(2,0,1,8'h03,0,3'b001,24'h0000F0, 8'hF0,1,3'b001,3'b000,3'b000));
        vecs.push_back(mk(2,0,1,8'h30,0,3'b000,24'h000000, 8'hC0,1,3'b000,3'b000,3'b000));
        vecs.push_back(mk(2,0,0,8'h00,1,3'b000,24'h000000, 8'hC0,0,3'b000,3'b000,3'b000));
        vecs.push_back(mk(2,0,1,8'h00,0,3'b000,24'h000000, 8'hC0,1,3'b000,3'b000,3'b000));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            vec_t e;
            @(negedge clk_i);
            v = vecs[i];
            rst_i = v.rst;
            we = v.we; wd = v.wd; re = v.re; de = v.de; d = v.d;
            sb.push_back(v);
            @(posedge clk_i);
            #1;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL vec %0d scoreboard: got empty queue expected one entry", i);
            end else begin
                e = sb.pop_front();
                n_vec++;
                chk(i, "q",       32'(q_o[e.sel]),    32'(e.q));
                chk(i, "qs",      32'(qs_o[e.sel]),   32'(e.q));
                chk(i, "qe",      32'(qe_o[e.sel]),   32'(e.qe));
                chk(i, "hw_ack",  32'(ack_o[e.sel]),  32'(e.ack));
                chk(i, "hw_drop", 32'(drop_o[e.sel]), 32'(e.drop));
                chk(i, "pend",    32'(pend_o[e.sel]), 32'(e.pend));
                $display("vec %0d dut%0d rst=%0b we=%0b wd=%02h re=%0b de=%03b d=%06h -> q=%02h qe=%0b ack=%03b drop=%03b pend=%03b",
                         i, e.sel, e.rst, e.we, e.wd, e.re, e.de, e.d,
                         q_o[e.sel], qe_o[e.sel], ack_o[e.sel], drop_o[e.sel], pend_o[e.sel]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
